// File: rtl/hdmi_demo_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_demo_pkg
// Shared constants for the 640x480 DVI/HDMI demo: default video timing and
// derived totals, the four DVI control tokens, the TMDS clock-lane symbol,
// the 10-bit symbol type, and small helpers used by the channel encoder.
// -----------------------------------------------------------------------------
package hdmi_demo_pkg;

   // Default 640x480@60 timing, in pixels / lines.
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FRONT_DEF  = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BACK_DEF   = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FRONT_DEF  = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BACK_DEF   = 33;

   localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF; // 800
   localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF; // 525
   localparam int HS_START_DEF = H_ACTIVE_DEF + H_FRONT_DEF;                           // 656
   localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;                            // 752 (exclusive)
   localparam int VS_START_DEF = V_ACTIVE_DEF + V_FRONT_DEF;                           // 490
   localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;                            // 492 (exclusive)

   localparam int HEARTBEAT_DIV_DEF = 16384;

   // Width of the pixel/line counters; holds any total up to 1023.
   localparam int CNT_W = 10;

   typedef logic [9:0] tmds_sym_t;

   // Control tokens indexed by {c1, c0}.
   localparam tmds_sym_t CTRL_00 = 10'b1101010100;
   localparam tmds_sym_t CTRL_01 = 10'b0010101011;
   localparam tmds_sym_t CTRL_10 = 10'b0101010100;
   localparam tmds_sym_t CTRL_11 = 10'b1010101011;

   // Clock lane: shifted LSB first, so high for bits 0-4 and low for 5-9.
   localparam tmds_sym_t CLK_SYMBOL = 10'b0000011111;

   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   // Transition-minimising stage: bit 8 = 1 means XOR chain, 0 means XNOR.
   function automatic logic [8:0] tmds_stage1(input logic [7:0] d);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] qm;
      n1       = ones8(d);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      qm       = 9'd0;
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++)
         qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8]    = ~use_xnor;
      return qm;
   endfunction

   function automatic tmds_sym_t ctrl_token(input logic [1:0] c);
      tmds_sym_t t;
      case (c)
         2'b00:   t = CTRL_00;
         2'b01:   t = CTRL_01;
         2'b10:   t = CTRL_10;
         default: t = CTRL_11;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/hdmi_demo_if.sv
// -----------------------------------------------------------------------------
// hdmi_demo_if
// Differential TMDS output bundle: three data lanes plus the clock lane.
//   tmds_p[2:0]   serialized data, [0]=blue/sync, [1]=green, [2]=red
//   tmds_n[2:0]   complement of tmds_p
//   tmds_clock_p  pixel-rate clock lane
//   tmds_clock_n  complement of tmds_clock_p
// There is no valid/ready handshake on this bundle: the source drives one
// bit per bit-clock continuously and the sink cannot apply backpressure.
// -----------------------------------------------------------------------------
interface hdmi_demo_if;
   logic [2:0] tmds_p;
   logic [2:0] tmds_n;
   logic       tmds_clock_p;
   logic       tmds_clock_n;

   modport master (output tmds_p, tmds_n, tmds_clock_p, tmds_clock_n);
   modport slave  (input  tmds_p, tmds_n, tmds_clock_p, tmds_clock_n);
endinterface

// File: rtl/hdmi_demo_tmds_channel_encoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_encoder
// DVI 8b/10b TMDS encoder for one lane, registered on en (pixel enable).
//   clk, rst_n  bit clock, asynchronous active-low reset
//   en          pixel enable; q and running disparity update only when set
//   de          1 = encode video data d, 0 = send control token for c
//   d[7:0]      pixel component
//   c[1:0]      control bits {c1, c0}
//   q[9:0]      encoded symbol, transmitted LSB first
// -----------------------------------------------------------------------------
module tmds_channel_encoder
   import hdmi_demo_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       de,
   input  logic [7:0] d,
   input  logic [1:0] c,
   output tmds_sym_t  q
);

   logic [8:0]        q_m;
   logic [3:0]        n1_q;
   logic signed [5:0] bal;      // ones minus zeros of q_m[7:0], -8..8
   logic signed [5:0] cnt;      // running disparity of the emitted stream
   logic signed [5:0] cnt_nxt;
   tmds_sym_t         q_nxt;

   always_comb begin
      q_m     = tmds_stage1(d);
      n1_q    = ones8(q_m[7:0]);
      bal     = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
      q_nxt   = '0;
      cnt_nxt = cnt;
      if (!de) begin
         q_nxt   = ctrl_token(c);
         cnt_nxt = 6'sd0;
      end else if ((cnt == 6'sd0) || (bal == 6'sd0)) begin
         // Bits 9 and 8 are complementary, so only the data byte moves cnt.
         q_nxt   = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
         cnt_nxt = q_m[8] ? (cnt + bal) : (cnt - bal);
      end else if (((cnt > 6'sd0) && (bal > 6'sd0)) || ((cnt < 6'sd0) && (bal < 6'sd0))) begin
         // Same sign as the running disparity: invert to pull it back.
         q_nxt   = {1'b1, q_m[8], ~q_m[7:0]};
         cnt_nxt = cnt + (q_m[8] ? 6'sd2 : 6'sd0) - bal;
      end else begin
         q_nxt   = {1'b0, q_m[8], q_m[7:0]};
         cnt_nxt = cnt - (q_m[8] ? 6'sd0 : 6'sd2) + bal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= '0;
         cnt <= 6'sd0;
      end else if (en) begin
         q   <= q_nxt;
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/hdmi_demo_top.sv
// -----------------------------------------------------------------------------
// hdmi_demo_top
// 640x480 DVI/HDMI test-pattern source for the MAX10 board. CLK_50MHZ is the
// TMDS bit clock; pixels advance every 10 clocks.
//   CLK_50MHZ         bit clock, all state on its rising edge
//   RST               asynchronous active-low reset
//   CLK_32KHZ         slow reference, sampled as data for the heartbeat
//   CLK_50MHZ_ENABLE  oscillator enable, constant 1
//   CLK_32KHZ_ENABLE  oscillator enable, constant 1
//   LED[7:0]          [6:0] frame counter, [7] heartbeat
//   tmds              TMDS lane bundle (see hdmi_demo_if)
// Pipeline: counters -> stage 1 (sync/de/RGB) -> stage 2 (encoders) ->
// serializers, which load one clock after the pixel enable so a counter value
// reaches the pins 2 pixel periods + 1 clock later.
// -----------------------------------------------------------------------------
module hdmi_demo_top
   import hdmi_demo_pkg::*;
#(
   parameter int H_ACTIVE      = H_ACTIVE_DEF,
   parameter int H_FRONT       = H_FRONT_DEF,
   parameter int H_SYNC        = H_SYNC_DEF,
   parameter int H_BACK        = H_BACK_DEF,
   parameter int V_ACTIVE      = V_ACTIVE_DEF,
   parameter int V_FRONT       = V_FRONT_DEF,
   parameter int V_SYNC        = V_SYNC_DEF,
   parameter int V_BACK        = V_BACK_DEF,
   parameter int HEARTBEAT_DIV = HEARTBEAT_DIV_DEF
)(
   input  logic        CLK_50MHZ,
   input  logic        RST,
   input  logic        CLK_32KHZ,
   output logic        CLK_50MHZ_ENABLE,
   output logic        CLK_32KHZ_ENABLE,
   output logic [7:0]  LED,
   hdmi_demo_if.master tmds
);

   localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam int               HB_W   = $clog2(HEARTBEAT_DIV + 1);
   localparam logic [HB_W-1:0]  HB_LAST = HB_W'(HEARTBEAT_DIV - 1);

   logic [3:0]       bit_cnt;
   logic             pix_en;
   logic             load;
   logic [CNT_W-1:0] cx, cy;
   logic [7:0]       frame_cnt;
   logic             unused_frame_msb;

   logic             de_raw, hs_raw, vs_raw;
   logic             s1_de, s1_hs, s1_vs;
   logic [7:0]       s1_r, s1_g, s1_b;

   tmds_sym_t        sym [3];
   tmds_sym_t        sh  [3];
   tmds_sym_t        clk_sh;

   logic [2:0]       s32;      // [1:0] synchronizer, [2] edge-detect history
   logic             hb_rise;
   logic [HB_W-1:0]  hb_cnt;
   logic             hb_led;

   assign CLK_50MHZ_ENABLE = 1'b1;
   assign CLK_32KHZ_ENABLE = 1'b1;

   assign pix_en = (bit_cnt == 4'd9);
   assign load   = (bit_cnt == 4'd0);

   always_ff @(posedge CLK_50MHZ or negedge RST) begin
      if (!RST) begin
         bit_cnt   <= 4'd0;
         cx        <= '0;
         cy        <= '0;
         frame_cnt <= 8'd0;
      end else begin
         bit_cnt <= pix_en ? 4'd0 : (bit_cnt + 4'd1);
         if (pix_en) begin
            if (cx == H_LAST) begin
               cx <= '0;
               if (cy == V_LAST) begin
                  cy        <= '0;
                  frame_cnt <= frame_cnt + 8'd1;
               end else begin
                  cy <= cy + CNT_W'(1);
               end
            end else begin
               cx <= cx + CNT_W'(1);
            end
         end
      end
   end

   assign de_raw = (cx < H_ACT) && (cy < V_ACT);
   assign hs_raw = !((cx >= HS_BEG) && (cx < HS_END));
   assign vs_raw = !((cy >= VS_BEG) && (cy < VS_END));

   // Stage 1 resets to an idle blanking state (syncs deasserted).
   always_ff @(posedge CLK_50MHZ or negedge RST) begin
      if (!RST) begin
         s1_de <= 1'b0;
         s1_hs <= 1'b1;
         s1_vs <= 1'b1;
         s1_r  <= 8'd0;
         s1_g  <= 8'd0;
         s1_b  <= 8'd0;
      end else if (pix_en) begin
         s1_de <= de_raw;
         s1_hs <= hs_raw;
         s1_vs <= vs_raw;
         s1_r  <= cx[7:0];
         s1_g  <= cy[7:0];
         s1_b  <= cx[7:0] ^ cy[7:0];
      end
   end

   tmds_channel_encoder u_enc_b (
      .clk(CLK_50MHZ), .rst_n(RST), .en(pix_en), .de(s1_de),
      .d(s1_b), .c({s1_vs, s1_hs}), .q(sym[0])
   );
   tmds_channel_encoder u_enc_g (
      .clk(CLK_50MHZ), .rst_n(RST), .en(pix_en), .de(s1_de),
      .d(s1_g), .c(2'b00), .q(sym[1])
   );
   tmds_channel_encoder u_enc_r (
      .clk(CLK_50MHZ), .rst_n(RST), .en(pix_en), .de(s1_de),
      .d(s1_r), .c(2'b00), .q(sym[2])
   );

   always_ff @(posedge CLK_50MHZ or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < 3; i++) sh[i] <= '0;
         clk_sh <= '0;
      end else if (load) begin
         for (int i = 0; i < 3; i++) sh[i] <= sym[i];
         clk_sh <= CLK_SYMBOL;
      end else begin
         for (int i = 0; i < 3; i++) sh[i] <= {1'b0, sh[i][9:1]};
         clk_sh <= {1'b0, clk_sh[9:1]};
      end
   end

   assign tmds.tmds_p       = {sh[2][0], sh[1][0], sh[0][0]};
   assign tmds.tmds_n       = ~{sh[2][0], sh[1][0], sh[0][0]};
   assign tmds.tmds_clock_p = clk_sh[0];
   assign tmds.tmds_clock_n = ~clk_sh[0];

   assign hb_rise = s32[1] & ~s32[2];

   always_ff @(posedge CLK_50MHZ or negedge RST) begin
      if (!RST) begin
         s32    <= 3'b000;
         hb_cnt <= '0;
         hb_led <= 1'b0;
      end else begin
         s32 <= {s32[1:0], CLK_32KHZ};
         if (hb_rise) begin
            if (hb_cnt == HB_LAST) begin
               hb_cnt <= '0;
               hb_led <= ~hb_led;
            end else begin
               hb_cnt <= hb_cnt + HB_W'(1);
            end
         end
      end
   end

   assign unused_frame_msb = frame_cnt[7];
   assign LED = {hb_led, frame_cnt[6:0]};

endmodule

// File: tb/tb_hdmi_demo_top.sv
// -----------------------------------------------------------------------------
// tb_hdmi_demo_top
// Bench for hdmi_demo_top with shrunken video timing so whole frames fit in a
// short run. The reference model derives each expected symbol from the pixel
// index (cx, cy from division/modulo), a DVI encoder written with integer
// disparity arithmetic, a DVI decoder, and an edge counter for the heartbeat.
// -----------------------------------------------------------------------------
module tb_hdmi_demo_top;

  localparam int HA = 40, HF = 4, HS = 8, HB = 8;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLKS = 10 * HT * VT;
  localparam int HBDIV = 4;
  localparam int W = 55;   // {de, r, g, b, sym2, sym1, sym0}

  localparam logic [9:0] TK00 = 10'b1101010100;
  localparam logic [9:0] TK01 = 10'b0010101011;
  localparam logic [9:0] TK10 = 10'b0101010100;
  localparam logic [9:0] TK11 = 10'b1010101011;

  logic       clk;
  logic       rst_n;
  logic       clk32;
  logic       en50, en32;
  logic [7:0] led;

  hdmi_demo_if tmds_if ();

  hdmi_demo_top #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HEARTBEAT_DIV(HBDIV)
  ) dut (
    .CLK_50MHZ(clk),
    .RST(rst_n),
    .CLK_32KHZ(clk32),
    .CLK_50MHZ_ENABLE(en50),
    .CLK_32KHZ_ENABLE(en32),
    .LED(led),
    .tmds(tmds_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int n;                      // rising edges since reset release
  logic [W-1:0] exp_q[$];
  int hb_q[$];                // edge index after which LED[7] flips
  int mcnt [3];               // model running disparity per lane
  int disp [3];               // disparity measured on the received stream
  logic [9:0] rx [3];
  logic exp_led7;
  int rise_cnt;
  int hold_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_encode(input logic [7:0] d, inout int cnt, output logic [9:0] q);
    int n1, n1q, bal, qm8;
    bit xn;
    logic [8:0] qm;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm = 9'd0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    qm8 = xn ? 0 : 1;
    n1q = $countones(qm[7:0]);
    bal = n1q - (8 - n1q);
    if (cnt == 0 || bal == 0) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      cnt = cnt + (qm8 == 1 ? bal : -bal);
    end else if ((cnt > 0 && bal > 0) || (cnt < 0 && bal < 0)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      cnt = cnt + 2 * qm8 - bal;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      cnt = cnt - 2 * (1 - qm8) + bal;
    end
  endtask

  function automatic logic [7:0] dvi_decode(input logic [9:0] s);
    logic [7:0] dd, o;
    dd = s[9] ? ~s[7:0] : s[7:0];
    o = 8'd0;
    o[0] = dd[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (dd[i] ^ dd[i-1]) : ~(dd[i] ^ dd[i-1]);
    return o;
  endfunction

  // Symbol 0 is the zeroed encoder register, symbol 1 encodes the idle
  // stage-1 reset state, symbol s >= 2 carries pixel s-2.
  task automatic model_symbol(input int s, output logic [W-1:0] e);
    int p, cx, cy;
    bit de, hs_n, vs_n;
    logic [7:0] r, g, b;
    logic [9:0] q0, q1, q2;
    if (s == 0) begin
      e = '0;
    end else if (s == 1) begin
      e = {1'b0, 24'h0, TK00, TK00, TK11};
    end else begin
      p  = s - 2;
      cx = p % HT;
      cy = (p / HT) % VT;
      de   = (cx < HA) && (cy < VA);
      hs_n = !((cx >= HA + HF) && (cx < HA + HF + HS));
      vs_n = !((cy >= VA + VF) && (cy < VA + VF + VS));
      r = 8'(cx);
      g = 8'(cy);
      b = r ^ g;
      if (de) begin
        model_encode(b, mcnt[0], q0);
        model_encode(g, mcnt[1], q1);
        model_encode(r, mcnt[2], q2);
      end else begin
        for (int c = 0; c < 3; c++) mcnt[c] = 0;
        case ({vs_n, hs_n})
          2'b00:   q0 = TK00;
          2'b01:   q0 = TK01;
          2'b10:   q0 = TK10;
          default: q0 = TK11;
        endcase
        q1 = TK00;
        q2 = TK00;
      end
      e = {de, r, g, b, q2, q1, q0};
    end
  endtask

  // ---------------- per-clock driver + checks ----------------
  task automatic step();
    int j, s;
    logic [W-1:0] e;
    logic [2:0] exp_p, exp_n;
    logic [7:0] dec, want;
    int d;
    @(posedge clk);
    @(negedge clk);
    n++;
    j = (n - 1) % 10;
    s = (n - 1) / 10;
    if (j == 0) begin
      model_symbol(s, e);
      exp_q.push_back(e);
    end
    e = exp_q[0];
    exp_p = {e[20 + j], e[10 + j], e[j]};
    exp_n = ~exp_p;
    check("tmds_p", 32'(tmds_if.tmds_p), 32'(exp_p));
    check("tmds_n", 32'(tmds_if.tmds_n), 32'(exp_n));
    check("clock_p", 32'(tmds_if.tmds_clock_p), (j < 5) ? 32'd1 : 32'd0);
    check("clock_n", 32'(tmds_if.tmds_clock_n), (j < 5) ? 32'd0 : 32'd1);
    for (int c = 0; c < 3; c++) rx[c][j] = tmds_if.tmds_p[c];

    if (j == 9) begin
      e = exp_q.pop_front();
      check("sym_blue", 32'(rx[0]), 32'(e[9:0]));
      check("sym_green", 32'(rx[1]), 32'(e[19:10]));
      check("sym_red", 32'(rx[2]), 32'(e[29:20]));
      if (e[54]) begin
        for (int c = 0; c < 3; c++) begin
          dec  = dvi_decode(rx[c]);
          want = (c == 0) ? e[37:30] : (c == 1) ? e[45:38] : e[53:46];
          check("decode", 32'(dec), 32'(want));
          disp[c] = disp[c] + 2 * $countones(rx[c]) - 10;
          d = disp[c];
          check("disparity_bound", (d >= -10 && d <= 10) ? 32'd1 : 32'd0, 32'd1);
        end
      end else begin
        for (int c = 0; c < 3; c++) disp[c] = 0;
      end
    end

    while (hb_q.size() > 0 && hb_q[0] <= n) begin
      void'(hb_q.pop_front());
      exp_led7 = ~exp_led7;
    end
    check("led_frame", 32'(led[6:0]), 32'((n / FRAME_CLKS) % 128));
    check("led_heartbeat", 32'(led[7]), 32'(exp_led7));
    check("enables", 32'({en50, en32}), 32'd3);

    // Slow reference: change level at this negedge; sampled at edge n+1,
    // through two sync flops and the edge detector, counted at edge n+3.
    hold_cnt--;
    if (hold_cnt <= 0) begin
      clk32 = ~clk32;
      hold_cnt = $urandom_range(1, 6);
      if (clk32) begin
        rise_cnt++;
        if (rise_cnt == HBDIV) begin
          rise_cnt = 0;
          hb_q.push_back(n + 3);
        end
      end
    end
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_tmds_p"}, 32'(tmds_if.tmds_p), 32'd0);
    check({tag, "_tmds_n"}, 32'(tmds_if.tmds_n), 32'd7);
    check({tag, "_clock_p"}, 32'(tmds_if.tmds_clock_p), 32'd0);
    check({tag, "_clock_n"}, 32'(tmds_if.tmds_clock_n), 32'd1);
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_enables"}, 32'({en50, en32}), 32'd3);
  endtask

  // Called at a negedge; leaves reset released just after a negedge.
  task automatic apply_reset(input int cycles, input bit mid_run);
    rst_n = 1'b0;
    clk32 = 1'b0;
    if (mid_run) begin
      #1;
      reset_checks("async_reset");
    end
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      reset_checks("reset");
    end
    rst_n = 1'b1;
    n = 0;
    exp_q.delete();
    hb_q.delete();
    for (int c = 0; c < 3; c++) begin
      mcnt[c] = 0;
      disp[c] = 0;
    end
    exp_led7 = 1'b0;
    rise_cnt = 0;
    hold_cnt = $urandom_range(1, 6);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    clk32 = 1'b0;
    n = 0;
    @(negedge clk);
    apply_reset(4, 1'b0);
    run(2 * FRAME_CLKS + 300);
    run($urandom_range(500, 3000));
    @(negedge clk);
    apply_reset($urandom_range(2, 6), 1'b1);
    run(1500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
